// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: shared constants for the CSI-2 RX line sequencer.
//   - data-type codes for frame/line headers
//   - bits-per-pixel, word-count granule and pixels-per-granule per RAW type
//   - line sequencer state enum
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;
    localparam logic [5:0] DT_RAW14 = 6'h2D;

    localparam int unsigned BPP_RAW10 = 10;
    localparam int unsigned BPP_RAW12 = 12;
    localparam int unsigned BPP_RAW14 = 14;

    // Smallest byte count that packs a whole number of 2-pixel beats.
    localparam int unsigned WC_GRAN_RAW10 = 10;
    localparam int unsigned WC_GRAN_RAW12 = 6;
    localparam int unsigned WC_GRAN_RAW14 = 14;

    localparam int unsigned PIX_GRAN_RAW10 = WC_GRAN_RAW10 * 8 / BPP_RAW10;
    localparam int unsigned PIX_GRAN_RAW12 = WC_GRAN_RAW12 * 8 / BPP_RAW12;
    localparam int unsigned PIX_GRAN_RAW14 = WC_GRAN_RAW14 * 8 / BPP_RAW14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_PAYLOAD,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/mipi_csi_rx_wc_check.sv
// mipi_csi_rx_wc_check: combinational word-count validation for RAW line headers.
// Ports:
//   dt       in  header data type
//   wc       in  header word count (bytes)
//   wc_ok    out wc nonzero, multiple of the type granule, dt is RAW10/12/14
//   expected out pixels the line should produce (wc*8/bpp)
// Division by the granule uses reciprocal multiplication by constants
// (shift-add), then multiplies back to prove exact divisibility.
module mipi_csi_rx_wc_check
    import mipi_csi_pkg::*;
#(
    parameter int WC_WIDTH = 16
) (
    input  logic [5:0]          dt,
    input  logic [WC_WIDTH-1:0] wc,
    output logic                wc_ok,
    output logic [15:0]         expected
);
    logic [31:0] half, wc32, q10, q6, q14;

    // Every granule is 2*odd, so divide wc/2 by 5, 3 or 7. Reciprocal
    // constants are exact for any half-word count below 2^15.
    assign wc32 = 32'(wc);
    assign half = 32'(wc >> 1);
    assign q10  = (half * 32'd52429) >> 18;
    assign q6   = (half * 32'd43691) >> 17;
    assign q14  = (half * 32'd37450) >> 18;

    always_comb begin
        wc_ok    = 1'b0;
        expected = '0;
        case (dt)
            DT_RAW10: begin
                wc_ok    = (wc32 != 0) && (q10 * WC_GRAN_RAW10 == wc32);
                expected = 16'(q10 * PIX_GRAN_RAW10);
            end
            DT_RAW12: begin
                wc_ok    = (wc32 != 0) && (q6 * WC_GRAN_RAW12 == wc32);
                expected = 16'(q6 * PIX_GRAN_RAW12);
            end
            DT_RAW14: begin
                wc_ok    = (wc32 != 0) && (q14 * WC_GRAN_RAW14 == wc32);
                expected = 16'(q14 * PIX_GRAN_RAW14);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mipi_csi_rx_line_sequencer.sv
// mipi_csi_rx_line_sequencer: frame/line controller in front of the 2-lane
// RAW depacker. Gates payload into the depacker, holds its packet type per
// line, waits for it to drain and checks the produced pixel count.
// Ports:
//   clk_i, reset_i (sync, active high)
//   pkt_valid_i/pkt_dt_i/pkt_wc_i     header strobe from packet decoder
//   payload_valid_i/payload_i         payload beats
//   depack_data_valid_o/depack_data_o/depack_packet_type_o  to depacker
//   depack_line_i/depack_out_valid_i  depacker status
//   frame_active_o, *_start_o/*_end_o pulses, line/pixel counts
//   err_wc_o/err_pix_o/err_seq_o      sticky errors
module mipi_csi_rx_line_sequencer
    import mipi_csi_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int WC_WIDTH       = 16,
    parameter int LINE_CNT_WIDTH = 16,
    parameter int DRAIN_MAX      = 15
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      pkt_valid_i,
    input  logic [5:0]                pkt_dt_i,
    input  logic [WC_WIDTH-1:0]       pkt_wc_i,
    input  logic                      payload_valid_i,
    input  logic [8*LANES-1:0]        payload_i,
    output logic                      depack_data_valid_o,
    output logic [8*LANES-1:0]        depack_data_o,
    output logic [2:0]                depack_packet_type_o,
    input  logic                      depack_line_i,
    input  logic                      depack_out_valid_i,
    output logic                      frame_active_o,
    output logic                      frame_start_o,
    output logic                      frame_end_o,
    output logic                      line_start_o,
    output logic                      line_end_o,
    output logic [LINE_CNT_WIDTH-1:0] line_count_o,
    output logic [15:0]               pixel_count_o,
    output logic                      err_wc_o,
    output logic                      err_pix_o,
    output logic                      err_seq_o
);
    localparam int DC_W = $clog2(DRAIN_MAX + 1);

    seq_state_t          state;
    logic [WC_WIDTH-1:0] remaining;
    logic [15:0]         expected, pixcnt, pix_next, wc_expected;
    logic [DC_W-1:0]     drain_cnt;
    logic                fe_pending, wc_ok, hdr_fe, hdr_fs, hdr_raw, drain_exit;

    mipi_csi_rx_wc_check #(.WC_WIDTH(WC_WIDTH)) u_wc_check (
        .dt       (pkt_dt_i),
        .wc       (pkt_wc_i),
        .wc_ok    (wc_ok),
        .expected (wc_expected)
    );

    assign hdr_fe  = pkt_valid_i && (pkt_dt_i == DT_FE);
    assign hdr_fs  = pkt_valid_i && (pkt_dt_i == DT_FS);
    assign hdr_raw = pkt_valid_i && (pkt_dt_i == DT_RAW10 || pkt_dt_i == DT_RAW12 ||
                                     pkt_dt_i == DT_RAW14);
    assign drain_exit = !depack_line_i || (drain_cnt == DC_W'(DRAIN_MAX - 1));

    // Include this cycle's depacker output so a pulse coinciding with the
    // drain exit is not lost from the line total.
    always_comb begin
        pix_next = pixcnt;
        if (depack_out_valid_i && (state == ST_PAYLOAD || state == ST_DRAIN))
            pix_next = (pixcnt >= 16'hFFFE) ? 16'hFFFF : pixcnt + 16'd2;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state                <= ST_IDLE;
            remaining            <= '0;
            expected             <= '0;
            pixcnt               <= '0;
            drain_cnt            <= '0;
            fe_pending           <= 1'b0;
            depack_data_valid_o  <= 1'b0;
            depack_data_o        <= '0;
            depack_packet_type_o <= 3'b011;
            frame_active_o       <= 1'b0;
            frame_start_o        <= 1'b0;
            frame_end_o          <= 1'b0;
            line_start_o         <= 1'b0;
            line_end_o           <= 1'b0;
            line_count_o         <= '0;
            pixel_count_o        <= '0;
            err_wc_o             <= 1'b0;
            err_pix_o            <= 1'b0;
            err_seq_o            <= 1'b0;
        end else begin
            frame_start_o       <= 1'b0;
            frame_end_o         <= 1'b0;
            line_start_o        <= 1'b0;
            line_end_o          <= 1'b0;
            depack_data_valid_o <= 1'b0;
            pixcnt              <= pix_next;
            case (state)
                ST_IDLE: begin
                    if (hdr_fs) begin
                        state          <= ST_FRAME;
                        frame_start_o  <= 1'b1;
                        frame_active_o <= 1'b1;
                        line_count_o   <= '0;
                    end else if (pkt_valid_i) begin
                        err_seq_o <= 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (hdr_fe) begin
                        frame_end_o    <= 1'b1;
                        frame_active_o <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (hdr_raw) begin
                        if (wc_ok) begin
                            remaining            <= pkt_wc_i;
                            expected             <= wc_expected;
                            depack_packet_type_o <= pkt_dt_i[2:0];
                            line_start_o         <= 1'b1;
                            pixcnt               <= '0;
                            state                <= ST_PAYLOAD;
                        end else begin
                            err_wc_o <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    drain_cnt <= '0;
                    if (payload_valid_i) begin
                        depack_data_o       <= payload_i;
                        depack_data_valid_o <= 1'b1;
                        if (remaining <= WC_WIDTH'(2)) begin
                            remaining <= '0;
                            state     <= ST_DRAIN;
                        end else begin
                            remaining <= remaining - WC_WIDTH'(2);
                        end
                    end
                    // Headers mid-line are protocol errors; FE aborts the line.
                    if (pkt_valid_i) begin
                        err_seq_o <= 1'b1;
                        if (hdr_fe) begin
                            fe_pending <= 1'b1;
                            state      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pkt_valid_i) err_seq_o <= 1'b1;
                    if (hdr_fe) fe_pending <= 1'b1;
                    if (drain_exit) begin
                        line_end_o    <= 1'b1;
                        pixel_count_o <= pix_next;
                        line_count_o  <= line_count_o + LINE_CNT_WIDTH'(1);
                        // Still busy here means timeout, which is a pixel error too.
                        if (depack_line_i || pix_next != expected) err_pix_o <= 1'b1;
                        if (fe_pending || hdr_fe) begin
                            frame_end_o    <= 1'b1;
                            frame_active_o <= 1'b0;
                            fe_pending     <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            state <= ST_FRAME;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mipi_csi_rx_line_sequencer.sv
// Directed bench for mipi_csi_rx_line_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are checked at that point.
module tb_mipi_csi_rx_line_sequencer;
    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        pkt_valid_i = 1'b0;
    logic [5:0]  pkt_dt_i = '0;
    logic [15:0] pkt_wc_i = '0;
    logic        payload_valid_i = 1'b0;
    logic [15:0] payload_i = '0;
    logic        depack_data_valid_o;
    logic [15:0] depack_data_o;
    logic [2:0]  depack_packet_type_o;
    logic        depack_line_i = 1'b0;
    logic        depack_out_valid_i = 1'b0;
    logic        frame_active_o, frame_start_o, frame_end_o, line_start_o, line_end_o;
    logic [15:0] line_count_o, pixel_count_o;
    logic        err_wc_o, err_pix_o, err_seq_o;

    int checks = 0;
    int failures = 0;
    int fwd_cnt = 0;
    int fwd_base;
    int k;

    mipi_csi_rx_line_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .pkt_valid_i(pkt_valid_i), .pkt_dt_i(pkt_dt_i), .pkt_wc_i(pkt_wc_i),
        .payload_valid_i(payload_valid_i), .payload_i(payload_i),
        .depack_data_valid_o(depack_data_valid_o), .depack_data_o(depack_data_o),
        .depack_packet_type_o(depack_packet_type_o),
        .depack_line_i(depack_line_i), .depack_out_valid_i(depack_out_valid_i),
        .frame_active_o(frame_active_o), .frame_start_o(frame_start_o),
        .frame_end_o(frame_end_o), .line_start_o(line_start_o), .line_end_o(line_end_o),
        .line_count_o(line_count_o), .pixel_count_o(pixel_count_o),
        .err_wc_o(err_wc_o), .err_pix_o(err_pix_o), .err_seq_o(err_seq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (depack_data_valid_o) fwd_cnt++;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hdr(input logic [5:0] dt, input logic [15:0] wc);
        pkt_valid_i = 1'b1;
        pkt_dt_i    = dt;
        pkt_wc_i    = wc;
        tick();
        pkt_valid_i = 1'b0;
    endtask

    // n back-to-back beats; depacker output pulses on the first nov of them.
    task automatic beats(input int n, input int nov, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            payload_valid_i    = 1'b1;
            payload_i          = base + 16'(i);
            depack_out_valid_i = (i < nov);
            tick();
        end
        payload_valid_i    = 1'b0;
        depack_out_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_dvalid", depack_data_valid_o, 0);
        chk("rst_ptype", depack_packet_type_o, 3'b011);
        chk("rst_factive", frame_active_o, 0);
        chk("rst_lcount", line_count_o, 0);
        chk("rst_errs", {err_wc_o, err_pix_o, err_seq_o}, 0);
        reset_i = 1'b0;

        // Non-FS header in IDLE
        hdr(6'h2C, 16'd12);
        chk("idle_hdr_errseq", err_seq_o, 1);
        chk("idle_hdr_nols", line_start_o, 0);

        // RAW10 wc=20 with only 4 depacker outputs -> 8 pixels, mismatch
        hdr(6'h00, 0);
        chk("fs_pulse", frame_start_o, 1);
        chk("fs_active", frame_active_o, 1);
        depack_line_i = 1'b1;
        hdr(6'h2B, 16'd20);
        chk("r10_ls", line_start_o, 1);
        chk("r10_ptype", depack_packet_type_o, 3'b011);
        fwd_base = fwd_cnt;
        beats(1, 1, 16'hA000);
        chk("r10_ls_pulse_off", line_start_o, 0);
        chk("r10_first_data", depack_data_o, 16'hA000);
        chk("r10_first_valid", depack_data_valid_o, 1);
        beats(9, 3, 16'hA001);
        chk("r10_last_data", depack_data_o, 16'hA009);
        depack_line_i = 1'b0;
        tick();
        chk("r10_fwd_cnt", fwd_cnt - fwd_base, 10);
        chk("r10_le", line_end_o, 1);
        chk("r10_pix8", pixel_count_o, 8);
        chk("r10_errpix", err_pix_o, 1);
        chk("r10_lcount", line_count_o, 1);

        // Rerun after reset with 8 outputs -> 16 pixels, no error
        do_reset();
        chk("rst2_errpix", err_pix_o, 0);
        hdr(6'h00, 0);
        depack_line_i = 1'b1;
        hdr(6'h2B, 16'd20);
        beats(10, 8, 16'hB000);
        depack_line_i = 1'b0;
        tick();
        chk("r10b_le", line_end_o, 1);
        chk("r10b_pix16", pixel_count_o, 16);
        chk("r10b_errpix", err_pix_o, 0);

        // Bad word count RAW12 wc=8, then stray beat in FRAME
        hdr(6'h2C, 16'd8);
        chk("badwc_err", err_wc_o, 1);
        chk("badwc_nols", line_start_o, 0);
        chk("badwc_ptype", depack_packet_type_o, 3'b011);
        beats(1, 0, 16'hC000);
        chk("badwc_nofwd", depack_data_valid_o, 0);
        // Still in FRAME: a good RAW12 header is accepted
        depack_line_i = 1'b1;
        hdr(6'h2C, 16'd12);
        chk("r12_ls", line_start_o, 1);
        chk("r12_ptype", depack_packet_type_o, 3'b100);
        beats(6, 4, 16'hC100);
        depack_line_i = 1'b0;
        tick();
        chk("r12_pix8", pixel_count_o, 8);
        chk("r12_errpix", err_pix_o, 0);

        // RAW14 wc=14 with 9 beats: 7 forwarded, CRC beats dropped
        depack_line_i = 1'b1;
        hdr(6'h2D, 16'd14);
        chk("r14_ptype", depack_packet_type_o, 3'b101);
        fwd_base = fwd_cnt;
        for (int i = 0; i < 9; i++) begin
            payload_valid_i    = 1'b1;
            payload_i          = 16'hD000 + 16'(i);
            depack_out_valid_i = (i < 4);
            tick();
            chk($sformatf("r14_beat%0d_valid", i), depack_data_valid_o, (i < 7) ? 1 : 0);
        end
        payload_valid_i    = 1'b0;
        depack_out_valid_i = 1'b0;
        chk("r14_last_data", depack_data_o, 16'hD006);
        depack_line_i = 1'b0;
        tick();
        chk("r14_fwd_cnt", fwd_cnt - fwd_base, 7);
        chk("r14_le", line_end_o, 1);
        chk("r14_pix8", pixel_count_o, 8);
        chk("r14_errpix", err_pix_o, 0);

        // Three lines then FE, then FS clears the line counter
        hdr(6'h01, 0);
        chk("fe_pulse", frame_end_o, 1);
        chk("fe_inactive", frame_active_o, 0);
        chk("fe_lcount3", line_count_o, 3);
        hdr(6'h00, 0);
        chk("fs_lcount0", line_count_o, 0);
        chk("fs2_pulse", frame_start_o, 1);

        // FE in the middle of payload
        chk("pre_fe_errseq", err_seq_o, 0);
        depack_line_i = 1'b1;
        hdr(6'h2B, 16'd20);
        beats(3, 0, 16'hE000);
        hdr(6'h01, 0);
        chk("femid_errseq", err_seq_o, 1);
        chk("femid_dvalid", depack_data_valid_o, 0);
        depack_line_i = 1'b0;
        tick();
        chk("femid_le", line_end_o, 1);
        chk("femid_fe", frame_end_o, 1);
        chk("femid_inactive", frame_active_o, 0);
        hdr(6'h00, 0);
        chk("femid_idle_fs", frame_start_o, 1);

        // Drain timeout: depack_line_i held high
        do_reset();
        hdr(6'h00, 0);
        depack_line_i = 1'b1;
        hdr(6'h2B, 16'd20);
        beats(10, 0, 16'hF000);
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (line_end_o) break;
        end
        chk("to_cycles", k, 15);
        chk("to_errpix", err_pix_o, 1);

        // Reset in the middle of a line
        hdr(6'h2D, 16'd14);
        beats(3, 0, 16'h1000);
        payload_valid_i = 1'b1;
        reset_i = 1'b1;
        tick();
        payload_valid_i = 1'b0;
        chk("midrst_dvalid", depack_data_valid_o, 0);
        chk("midrst_pulses", {line_end_o, frame_end_o, line_start_o, frame_start_o}, 0);
        chk("midrst_factive", frame_active_o, 0);
        chk("midrst_ptype", depack_packet_type_o, 3'b011);
        chk("midrst_errs", {err_wc_o, err_pix_o, err_seq_o}, 0);
        chk("midrst_counts", {line_count_o, pixel_count_o}, 0);
        reset_i = 1'b0;
        tick();
        chk("postrst_pulses", {line_end_o, frame_end_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
